// File: rtl/next_memory_pkg.sv
// next_memory_pkg: shared sizes, I/O word addresses and read-source select for the data memory
package next_memory_pkg;
  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 32;
  localparam logic [13:0] GPIO_ADDR = 14'h047;
  localparam logic [13:0] UART_IO_ADDR = 14'h048;
  localparam logic [13:0] UART_CSR_ADDR = 14'h049;
  typedef enum logic [1:0] {IO_NONE, IO_GPIO, IO_UART, IO_CSR} io_sel_e;
endpackage

// File: rtl/next_memory_ram.sv
// next_memory_ram: simple dual-port read-first RAM with a registered, enable-gated read port
module next_memory_ram #(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/next_memory.sv
// next_memory: word-addressed data RAM with GPIO/UART registers overlaid and mirrored into RAM
module next_memory #(
  parameter int ADDR_WIDTH = next_memory_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = next_memory_pkg::DATA_WIDTH,
  parameter string INIT_FILE = "",
  parameter logic [ADDR_WIDTH-1:0] GPIO_ADDR = next_memory_pkg::GPIO_ADDR,
  parameter logic [ADDR_WIDTH-1:0] UART_IO_ADDR = next_memory_pkg::UART_IO_ADDR,
  parameter logic [ADDR_WIDTH-1:0] UART_CSR_ADDR = next_memory_pkg::UART_CSR_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [1:0]            ben,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] io_gpio_io_reg,
  output logic [DATA_WIDTH-1:0] io_uart_io_reg,
  output logic [DATA_WIDTH-1:0] io_uart_csr_reg
);
  import next_memory_pkg::*;
  function automatic io_sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    return a == GPIO_ADDR ? IO_GPIO : a == UART_IO_ADDR ? IO_UART : a == UART_CSR_ADDR ? IO_CSR : IO_NONE;
  endfunction
  logic wr;
  io_sel_e wsel, rsel, rsel_q;
  logic [DATA_WIDTH-1:0] io_rd, io_q, ram_q;
  logic clr_q;
  assign wr = wen && ben == 2'd0;
  always_comb begin
    wsel = wr ? decode(waddr) : IO_NONE;
    rsel = decode(raddr);
    io_rd = rsel == IO_GPIO ? io_gpio_io_reg : rsel == IO_UART ? io_uart_io_reg : io_uart_csr_reg;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      io_gpio_io_reg <= '0;
      io_uart_io_reg <= '0;
      io_uart_csr_reg <= '0;
    end else begin
      io_gpio_io_reg <= wsel == IO_GPIO ? wdata : io_gpio_io_reg;
      io_uart_io_reg <= wsel == IO_UART ? wdata : io_uart_io_reg;
      io_uart_csr_reg <= wsel == IO_CSR ? wdata : io_uart_csr_reg;
    end
  end
  // The RAM read register has no reset, so clr_q masks it to zero until the first real read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_q <= 1'b1;
      rsel_q <= IO_NONE;
      io_q <= '0;
    end else if (ren) begin
      clr_q <= 1'b0;
      rsel_q <= rsel;
      io_q <= io_rd;
    end
  end
  assign rdata = clr_q ? '0 : rsel_q == IO_NONE ? ram_q : io_q;
  next_memory_ram #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .INIT_FILE(INIT_FILE)) u_ram (
    .clk(clk),
    .we(rst && wr),
    .waddr(waddr),
    .wdata(wdata),
    .re(rst && ren),
    .raddr(raddr),
    .q(ram_q)
  );
endmodule

// File: tb/tb_next_memory.sv
// tb_next_memory: directed and random checks of next_memory against an array-based memory model
module tb_next_memory;
  logic clk = 0, rst = 0, wen = 0, ren = 0;
  logic [13:0] waddr = 0, raddr = 0;
  logic [1:0] ben = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata, gpio, uart, csr;
  int total = 0, bad = 0;
  logic [31:0] mm [16384];
  bit kn [16384];
  logic [31:0] m_gpio = 0, m_uart = 0, m_csr = 0, m_rd = 0;
  bit m_rdk = 0, live = 0;

  next_memory dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .waddr(waddr), .raddr(raddr),
    .ben(ben), .wdata(wdata), .rdata(rdata), .io_gpio_io_reg(gpio),
    .io_uart_io_reg(uart), .io_uart_csr_reg(csr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: a flat word array plus three registers; reads take the pre-write value.
  always @(posedge clk) begin
    if (!rst) begin
      m_gpio = 0; m_uart = 0; m_csr = 0; m_rd = 0; m_rdk = 1;
    end else begin
      if (ren) begin
        m_rdk = 1;
        if (raddr == 14'h047) m_rd = m_gpio;
        else if (raddr == 14'h048) m_rd = m_uart;
        else if (raddr == 14'h049) m_rd = m_csr;
        else begin
          m_rd = mm[raddr];
          m_rdk = kn[raddr];
        end
      end
      if (wen && ben == 2'd0) begin
        mm[waddr] = wdata;
        kn[waddr] = 1;
        if (waddr == 14'h047) m_gpio = wdata;
        if (waddr == 14'h048) m_uart = wdata;
        if (waddr == 14'h049) m_csr = wdata;
      end
    end
    live = 1;
  end

  always @(negedge clk) if (live) begin
    chk("model_gpio", gpio, m_gpio);
    chk("model_uart", uart, m_uart);
    chk("model_csr", csr, m_csr);
    if (m_rdk) chk("model_rdata", rdata, m_rd);
  end

  task automatic step(input logic r, input logic we, input logic re, input logic [13:0] wa,
                      input logic [13:0] ra, input logic [1:0] b, input logic [31:0] wd);
    rst = r; wen = we; ren = re; waddr = wa; raddr = ra; ben = b; wdata = wd;
    @(negedge clk);
  endtask

  function automatic logic [13:0] pick();
    case ($urandom_range(3))
      0: return 14'h047 + 14'($urandom_range(2));
      1: return 14'h010 + 14'($urandom_range(15));
      2: return 14'h3FF0 + 14'($urandom_range(15));
      default: return 14'($urandom);
    endcase
  endfunction

  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_gpio", gpio, 32'h0);
    chk("rst_uart", uart, 32'h0);
    chk("rst_csr", csr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    step(1, 1, 0, 14'h047, 0, 0, 32'h3E6);
    chk("gpio_wr", gpio, 32'h3E6);
    chk("gpio_wr_uart", uart, 32'h0);
    chk("gpio_wr_csr", csr, 32'h0);
    step(1, 1, 0, 14'h010, 0, 0, 32'hDEADBEEF);
    step(1, 0, 1, 0, 14'h010, 0, 0);
    chk("ram_readback", rdata, 32'hDEADBEEF);
    step(1, 1, 0, 14'h020, 0, 0, 32'h1);
    step(1, 1, 1, 14'h020, 14'h020, 0, 32'h2);
    chk("read_first_old", rdata, 32'h1);
    step(1, 0, 1, 0, 14'h020, 0, 0);
    chk("read_first_new", rdata, 32'h2);
    step(1, 0, 0, 0, 14'h010, 0, 0);
    chk("rdata_hold", rdata, 32'h2);
    step(1, 1, 0, 14'h048, 0, 2'b01, 32'h55);
    chk("misaligned_wr", uart, 32'h0);
    step(1, 0, 1, 0, 14'h010, 2'b11, 0);
    chk("misaligned_rd", rdata, 32'hDEADBEEF);
    step(1, 1, 0, 14'h049, 0, 0, 32'hAA);
    chk("csr_wr", csr, 32'hAA);
    step(0, 1, 1, 14'h049, 14'h049, 0, 32'hBB);
    chk("rst_mid_csr", csr, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    step(1, 0, 1, 0, 14'h049, 0, 0);
    chk("csr_rd_after_rst", rdata, 32'h0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(49) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1, pick(), pick(),
           $urandom_range(3) == 0 ? 2'($urandom) : 2'd0, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
